// File: rtl/arith_pkg.sv
// arith_pkg: shared state and opcode encodings for the serial add/sub unit.
package arith_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/serial_addsub_if.sv
// serial_addsub_if: start/busy/done handshake and operand/result bus.
interface serial_addsub_if #(parameter int WIDTH = 32);
   logic             start;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   modport master (output start, op, a, b, cin, input busy, done, sum, cout, ovf);
   modport slave  (input start, op, a, b, cin, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/addsub_digit.sv
// addsub_digit: combinational DIGIT-bit ripple adder exposing the carry into its top bit.
module addsub_digit #(parameter int DIGIT = 1) (
   input  logic [DIGIT-1:0] a_d,
   input  logic [DIGIT-1:0] b_d,
   input  logic             c_in,
   output logic [DIGIT-1:0] s_d,
   output logic             c_out,
   output logic             c_msb_in
);
   logic [DIGIT:0] c;
   assign c[0] = c_in;
   for (genvar i = 0; i < DIGIT; i++) begin : g_bit
      assign s_d[i]   = a_d[i] ^ b_d[i] ^ c[i];
      assign c[i+1]   = (a_d[i] & b_d[i]) | (c[i] & (a_d[i] ^ b_d[i]));
   end
   assign c_out    = c[DIGIT];
   assign c_msb_in = c[DIGIT-1];
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: digit-serial add/subtract, DIGIT bits per clock, LSB first.
// Define SERIAL_ADDSUB_DEBUG_EN to expose the counter and operand shift registers.
module serial_addsub
   import arith_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIGIT = 1,
   parameter int CNT_W = $clog2(WIDTH/DIGIT) + 1
) (
   input logic clk,
   input logic rst_n,
   serial_addsub_if.slave bus
`ifdef SERIAL_ADDSUB_DEBUG_EN
   ,
   output logic [CNT_W-1:0] dbg_count,
   output logic [WIDTH-1:0] dbg_a_r,
   output logic [WIDTH-1:0] dbg_b_r
`endif
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH/DIGIT - 1);
   state_t           state, state_n;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] a_r, b_r, sum_r;
   logic             c_r, cout_r, ovf_r, done_r, accept, last;
   logic [DIGIT-1:0] s_d;
   logic             c_out, c_msb_in;
   addsub_digit #(.DIGIT(DIGIT)) u_digit (
      .a_d(a_r[DIGIT-1:0]), .b_d(b_r[DIGIT-1:0]), .c_in(c_r),
      .s_d(s_d), .c_out(c_out), .c_msb_in(c_msb_in)
   );
   always_comb begin
      accept  = bus.start && state != RUN;
      last    = state == RUN && cnt == LAST;
      state_n = accept ? RUN : last ? DONE : state;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   // Subtraction is folded in at accept: B is inverted and the borrow becomes ~cin.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         a_r    <= '0;
         b_r    <= '0;
         sum_r  <= '0;
         c_r    <= 1'b0;
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
         done_r <= 1'b0;
      end else begin
         if (accept) begin
            cnt <= '0;
            a_r <= bus.a;
            b_r <= bus.op == OP_SUB ? ~bus.b : bus.b;
            c_r <= bus.op == OP_SUB ? ~bus.cin : bus.cin;
         end else if (state == RUN) begin
            cnt   <= cnt + 1'b1;
            a_r   <= a_r >> DIGIT;
            b_r   <= b_r >> DIGIT;
            c_r   <= c_out;
            sum_r <= (sum_r >> DIGIT) | (WIDTH'(s_d) << (WIDTH - DIGIT));
            if (last) begin
               cout_r <= c_out;
               ovf_r  <= c_out ^ c_msb_in;
            end
         end
         done_r <= last;
      end
   end
   assign bus.busy = state == RUN;
   assign bus.done = done_r;
   assign bus.sum  = sum_r;
   assign bus.cout = cout_r;
   assign bus.ovf  = ovf_r;
`ifdef SERIAL_ADDSUB_DEBUG_EN
   assign dbg_count = cnt;
   assign dbg_a_r   = a_r;
   assign dbg_b_r   = b_r;
`endif
endmodule
